program_loader: RTL

Hardware program/data loader in front of the pipelined RISC-V CPU. It is the writer side of the instruction and data memory images that the CPU executes and the bench inspects. A host streams a framed byte image; the block assembles little-endian instruction words into instruction memory, writes initial data-memory bytes, verifies a checksum, then releases the CPU from reset and asserts start.

---
 rtl/program_loader_pkg.sv | 22 ++
 rtl/program_loader_if.sv | 34 +++
 rtl/program_loader_byte_to_word_packer.sv | 37 +++
 rtl/program_loader.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
package program_loader_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int DMEM_BYTES = 32;
  localparam int IMEM_AW    = 8;
  localparam int DMEM_AW    = 5;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR_N,
    HDR_M,
    IMEM,
    DMEM,
    CHK,
    RUN,
    ERR
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream, memory write ports and status of the program loader.
// The slave modport is the loader; the master modport is the host/CPU side.
interface program_loader_if;
  import program_loader_pkg::*;

  logic                s_valid_i;
  logic [7:0]          s_data_i;
  logic                s_ready_o;
  logic                imem_we_o;
  logic [IMEM_AW-1:0]  imem_addr_o;
  logic [31:0]         imem_data_o;
  logic                dmem_we_o;
  logic [DMEM_AW-1:0]  dmem_addr_o;
  logic [7:0]          dmem_data_o;
  logic                cpu_rst_o;
  logic                start_o;
  logic                done_o;
  logic                err_o;

  modport master (
    output s_valid_i, s_data_i,
    input  s_ready_o, imem_we_o, imem_addr_o, imem_data_o,
           dmem_we_o, dmem_addr_o, dmem_data_o,
           cpu_rst_o, start_o, done_o, err_o
  );

  modport slave (
    input  s_valid_i, s_data_i,
    output s_ready_o, imem_we_o, imem_addr_o, imem_data_o,
           dmem_we_o, dmem_addr_o, dmem_data_o,
           cpu_rst_o, start_o, done_o, err_o
  );

endinterface

// File: rtl/program_loader_byte_to_word_packer.sv
// Assembles four bytes, least significant first, into a 32-bit word.
// word/word_done are valid in the cycle the fourth byte is presented.
module byte_to_word_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  byte_cnt;
  logic [23:0] low_bytes;

  // Completed word combines the current byte with the three already held.
  always_comb begin
    word_done = in_valid && (byte_cnt == 2'd3);
    word      = {in_byte, low_bytes};
  end

  // Byte counter and shift register; new bytes enter at the top so the
  // first byte ends up in the least significant position.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      byte_cnt  <= '0;
      low_bytes <= '0;
    end else if (clr) begin
      byte_cnt  <= '0;
      low_bytes <= '0;
    end else if (in_valid) begin
      byte_cnt  <= byte_cnt + 2'd1;
      low_bytes <= {in_byte, low_bytes[23:8]};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Framed image loader: header, instruction words, data bytes, checksum,
// then releases the CPU. RUN and ERR are left only through reset.
//
// state | meaning
// IDLE  | hunting for the frame start marker
// HDR_N | next byte is the instruction word count
// HDR_M | next byte is the data byte count
// IMEM  | receiving instruction word bytes
// DMEM  | receiving data bytes
// CHK   | next byte is the checksum
// RUN   | load good, CPU released and started
// ERR   | load aborted
module program_loader
  import program_loader_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  program_loader_if.slave  bus
);

  state_t       state, state_nxt;
  logic         ready_en;
  logic         ready;
  logic         accept;
  logic         pack_in;
  logic         word_done;
  logic [31:0]  word;
  logic [7:0]   n_q;
  logic [5:0]   m_q;
  logic [7:0]   csum;
  logic [7:0]   word_idx;
  logic [5:0]   dmem_idx;
  logic         m_over;

  assign accept  = bus.s_valid_i & ready;
  assign pack_in = accept && (state == IMEM);
  assign m_over  = bus.s_data_i > 8'(DMEM_BYTES);

  byte_to_word_packer u_packer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr       (state == IDLE),
    .in_valid  (pack_in),
    .in_byte   (bus.s_data_i),
    .word      (word),
    .word_done (word_done)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; only an accepted byte moves the frame forward.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept && bus.s_data_i == HDR_BYTE) state_nxt = HDR_N;
      HDR_N: if (accept) state_nxt = HDR_M;
      HDR_M: begin
        if (accept) begin
          if (m_over)                     state_nxt = ERR;
          else if (n_q != '0)             state_nxt = IMEM;
          else if (bus.s_data_i != 8'd0)  state_nxt = DMEM;
          else                            state_nxt = CHK;
        end
      end
      IMEM: begin
        if (pack_in && word_done && word_idx == n_q - 8'd1)
          state_nxt = (m_q != '0) ? DMEM : CHK;
      end
      DMEM:  if (accept && dmem_idx == m_q - 6'd1) state_nxt = CHK;
      CHK:   if (accept) state_nxt = (bus.s_data_i == csum) ? RUN : ERR;
      default: state_nxt = state;
    endcase
  end

  // Status outputs decoded from state; ready stays low until the first
  // clock edge after reset is released.
  always_comb begin
    ready         = ready_en && (state != RUN) && (state != ERR);
    bus.s_ready_o = ready;
    bus.cpu_rst_o = (state == RUN);
    bus.start_o   = (state == RUN);
    bus.done_o    = (state == RUN);
    bus.err_o     = (state == ERR);
  end

  // Ready enable.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Frame counters and running checksum; N seeds the checksum.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      n_q      <= '0;
      m_q      <= '0;
      csum     <= '0;
      word_idx <= '0;
      dmem_idx <= '0;
    end else if (state == IDLE) begin
      csum     <= '0;
      word_idx <= '0;
      dmem_idx <= '0;
    end else if (accept) begin
      case (state)
        HDR_N: begin
          n_q  <= bus.s_data_i;
          csum <= bus.s_data_i;
        end
        HDR_M: begin
          m_q  <= bus.s_data_i[5:0];
          csum <= csum ^ bus.s_data_i;
        end
        IMEM: begin
          csum <= csum ^ bus.s_data_i;
          if (word_done) word_idx <= word_idx + 8'd1;
        end
        DMEM: begin
          csum     <= csum ^ bus.s_data_i;
          dmem_idx <= dmem_idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Registered memory write ports; address/data hold between strobes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.imem_we_o   <= 1'b0;
      bus.imem_addr_o <= '0;
      bus.imem_data_o <= '0;
      bus.dmem_we_o   <= 1'b0;
      bus.dmem_addr_o <= '0;
      bus.dmem_data_o <= '0;
    end else begin
      bus.imem_we_o <= pack_in && word_done;
      if (pack_in && word_done) begin
        bus.imem_addr_o <= word_idx;
        bus.imem_data_o <= word;
      end
      bus.dmem_we_o <= accept && (state == DMEM);
      if (accept && (state == DMEM)) begin
        bus.dmem_addr_o <= dmem_idx[4:0];
        bus.dmem_data_o <= bus.s_data_i;
      end
    end
  end

endmodule
